systolic_array_arbiter: RTL
===========================

# systolic_array_arbiter

Arbitrates a single weight-stationary systolic array, together with its matmul sequencing FSM, between two requesters: the host matmul path (requester 0) and the BIST/recompute path (requester 1). It grants the array with round-robin fairness and steers the granted requester's matrices into the FSM. It restarts the FSM by pulsing the FSM's synchronous reset, then detects job completion from the FSM's per-column output-valid signals. It sits directly above the matmul FSM in the BISR recompute-unit hierarchy.

## Interface
- COLS, default `COLS (header_ws.vh): array columns; width of the valid vector.
- TIMEOUT_CYCLES, default 64: watchdog limit in clk cycles, counted in RUN only.
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req  in  2  request per requester; level, held until its done pulse.
- output_col_valid  in  COLS  per-column valid from matmul FSM.
- grant  out  2  one-hot grant; high from LAUNCH through RUN.
- src_sel  out  1  index of granted requester; drives the top_matrix/left_matrix mux.
- fsm_rst  out  1  synchronous reset to the matmul FSM.
- done  out  2  one-cycle completion pulse to the granted requester.
- busy  out  1  high whenever state != IDLE.
- timeout_err  out  1  sticky watchdog flag.

## Operation
- States: IDLE, LAUNCH, RUN, RELEASE.
- **IDLE**
  - No req: stay in IDLE.
  - One req: grant it.
  - Both req: grant the requester != last_grant.
  - On any grant: register grant and src_sel, update last_grant, go to LAUNCH.
- **LAUNCH**: fsm_rst=1 for exactly one cycle; clear seen_valid; go to RUN.
- **RUN**
  - Track prev_last = output_col_valid[COLS-1] from the previous cycle.
  - Set seen_valid when output_col_valid[COLS-1]==1.
  - Job completes when seen_valid==1, prev_last==1 and output_col_valid[COLS-1]==0 (falling edge of the last column); then go to RELEASE.
  - Valid activity on the lower columns alone never completes a job.
- **RELEASE**
  - done[src_sel]=1, grant=0.
  - Go to IDLE.
- Requester behaviour:
  - A requester must drop req in the cycle after its done pulse. If it does not, it is re-arbitrated as a new job.
  - Deasserting req during LAUNCH/RUN is ignored; an in-flight job always runs to completion.
- src_sel holds its value in IDLE; it is not cleared on release.
- Outputs required in every state other than as stated above: grant=0, done=0, fsm_rst=0.

## Timing
- Reset values:
  - State IDLE.
  - grant=0, done=0, src_sel=0, busy=0, timeout_err=0.
  - last_grant=1, so requester 0 wins the first tie.
  - seen_valid=0, prev_last=0, watchdog count=0.
- fsm_rst = rst OR (state==LAUNCH), so the FSM is held in INIT during reset.
- Request sampled in IDLE at cycle N:
  - grant and fsm_rst high at N+1.
  - RUN from N+2.
- Falling edge of the last column sampled at cycle F: done pulses at F+1.
- IDLE resumes at F+2; the earliest next grant is at F+3.
- Simultaneous new request and done: the new request is not seen until IDLE, with no bypass path.
- rst mid-job (any state):
  - Return to reset values next cycle.
  - No done pulse.
  - The FSM is held in reset by fsm_rst.

## Configuration
- ARRAY_ARB_WATCHDOG_EN defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter clears in LAUNCH and increments each RUN cycle.
  - When it reaches TIMEOUT_CYCLES without completion: timeout_err<=1 (sticky until rst), and go to RELEASE, which pulses done normally.
  - If completion and timeout occur in the same cycle, completion wins and timeout_err is not set.
- ARRAY_ARB_WATCHDOG_EN undefined:
  - No counter is built; timeout_err is tied to 0.
  - RUN waits indefinitely for completion.

## Test plan
- Reset then req=2'b01 at cycle 0:
  - grant=01 and fsm_rst=1 at cycle 1.
  - Drive output_col_valid[COLS-1] high at cycles 8–11, low at 12 → done=01 at cycle 13, busy=0 at 14.
- req=2'b11 held through four jobs → grants alternate 01,10,01,10; each done pulses on the matching bit.
- In RUN, pulse only output_col_valid[0] for 20 cycles → no done; grant is held.
- rst asserted mid-RUN → next cycle grant=0, busy=0, done=0, fsm_rst=1 while rst is high.
- Watchdog (macro defined, TIMEOUT_CYCLES=16):
  - Never assert valid → timeout_err=1 and done pulse at LAUNCH+17.
  - The next job completes normally with timeout_err still 1.
- Macro undefined, same stimulus → grant is held for 200 cycles and timeout_err stays 0.

Source files
------------

// File: rtl/systolic_array_arbiter.sv
// Round-robin arbiter that shares one systolic array and its matmul FSM between two requesters.
// Optional watchdog on RUN is built when ARRAY_ARB_WATCHDOG_EN is defined.
module systolic_array_arbiter #(
  parameter int COLS           = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [COLS-1:0] output_col_valid,
  output logic [1:0]      grant,
  output logic            src_sel,
  output logic            fsm_rst,
  output logic [1:0]      done,
  output logic            busy,
  output logic            timeout_err
);

  // state   | meaning
  // IDLE    | array free, arbitrating requests
  // LAUNCH  | grant registered, matmul FSM held in reset for one cycle
  // RUN     | job in flight, watching the last column for its falling edge
  // RELEASE | done pulse to the granted requester, grant dropped
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LAUNCH  = 2'd1,
    S_RUN     = 2'd2,
    S_RELEASE = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   src_sel_q, src_sel_d;
  logic   last_grant_q, last_grant_d;
  logic   seen_valid_q, seen_valid_d;
  logic   prev_last_q, prev_last_d;
  logic   pick;
  logic   last_col;
  logic   complete;
  logic   wd_expire;
  logic   unused_ok;
  logic [1:0] sel_onehot;

  assign last_col  = output_col_valid[COLS-1];
  assign complete  = seen_valid_q & prev_last_q & ~last_col;
  assign unused_ok = ^output_col_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      src_sel_q    <= 1'b0;
      last_grant_q <= 1'b1;
      seen_valid_q <= 1'b0;
      prev_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_sel_q    <= src_sel_d;
      last_grant_q <= last_grant_d;
      seen_valid_q <= seen_valid_d;
      prev_last_q  <= prev_last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    src_sel_d    = src_sel_q;
    last_grant_d = last_grant_q;
    seen_valid_d = seen_valid_q;
    prev_last_d  = prev_last_q;
    pick         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          // On a tie the requester that did not win last time goes next.
          pick         = (req == 2'b11) ? ~last_grant_q : req[1];
          src_sel_d    = pick;
          last_grant_d = pick;
          state_d      = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        seen_valid_d = 1'b0;
        prev_last_d  = 1'b0;
        state_d      = S_RUN;
      end
      S_RUN: begin
        prev_last_d = last_col;
        if (last_col) seen_valid_d = 1'b1;
        if (complete || wd_expire) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ARRAY_ARB_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDW-1:0] wd_q, wd_d;
  logic           timeout_q, timeout_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  // Expiry fires on the RUN cycle whose increment would reach the limit; completion takes priority.
  always_comb begin
    wd_d      = wd_q;
    timeout_d = timeout_q;
    wd_expire = 1'b0;
    if (state_q == S_LAUNCH) begin
      wd_d = '0;
    end else if (state_q == S_RUN) begin
      wd_d = wd_q + WDW'(1);
      if (!complete && (wd_q == WDW'(TIMEOUT_CYCLES - 1))) begin
        wd_expire = 1'b1;
        timeout_d = 1'b1;
      end
    end
  end

  assign timeout_err = timeout_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign sel_onehot = src_sel_q ? 2'b10 : 2'b01;
  assign grant      = ((state_q == S_LAUNCH) || (state_q == S_RUN)) ? sel_onehot : 2'b00;
  assign done       = (state_q == S_RELEASE) ? sel_onehot : 2'b00;
  assign src_sel    = src_sel_q;
  assign busy       = (state_q != S_IDLE);
  // Held in reset alongside the arbiter so the matmul FSM restarts cleanly after rst.
  assign fsm_rst    = rst | (state_q == S_LAUNCH);

endmodule
